// File: rtl/reg_scoreboard.sv
// Scoreboard for destinations of in-flight long-latency ops (loads, PIM).
// Raises a decode stall on RAW/WAW hazards against them, or when no slot is free.
module reg_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 11,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [6:0]    i_opcode,
    input  logic [4:0]    i_rs1,
    input  logic [4:0]    i_rs2,
    input  logic          i_issue_valid,
    input  logic          i_issue_reg_write,
    input  logic [4:0]    i_issue_rd,
    input  logic          i_issue_long,
    input  logic          i_wb_reg_write,
    input  logic [4:0]    i_wb_rd,
    output logic          o_stall,
    output logic [31:0]   o_pending,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_timeout
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_PIM    = 7'b0001011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [31:0]      pending_q, pending_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             timeout_q;

    logic no_rs1, use_rs2;
    logic rs1_used, rs2_used;
    logic [31:0] wb_mask, pend_eff, set_mask, clr_mask;
    logic raw, waw, full_blk, long_wr;
    logic set, clr, stall;

    assign no_rs1  = i_opcode inside {OP_JAL, OP_LUI, OP_AUIPC};
    assign use_rs2 = i_opcode inside {OP_R, OP_STORE, OP_BRANCH, OP_PIM};

    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        unique case (1'b1)
            no_rs1:  rs1_used = 1'b0;
            use_rs2: rs2_used = 1'b1;
            default: ;
        endcase
    end

    // Same-cycle writeback is covered by forwarding, so it never stalls.
    assign wb_mask  = i_wb_reg_write ? (32'd1 << i_wb_rd) : 32'd0;
    assign pend_eff = pending_q & ~wb_mask;

    assign raw = (rs1_used & pend_eff[i_rs1])
               | (rs2_used & pend_eff[i_rs2]);
    assign waw = i_issue_reg_write & pend_eff[i_issue_rd];

    assign clr = i_wb_reg_write & (i_wb_rd != 5'd0)
               & pending_q[i_wb_rd];

    assign long_wr  = i_issue_long & i_issue_reg_write
                    & (i_issue_rd != 5'd0);
    assign full_blk = long_wr & o_full & ~clr;

    assign stall = i_issue_valid & (raw | waw | full_blk);
    assign set   = i_issue_valid & ~stall & long_wr;

    assign set_mask = set ? (32'd1 << i_issue_rd) : 32'd0;
    assign clr_mask = clr ? (32'd1 << i_wb_rd) : 32'd0;

    always_comb begin
        pending_d = (pending_q & ~clr_mask) | set_mask;
        count_d   = count_q;
        unique case ({set, clr})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        wd_d = wd_q;
        if (pending_q == 32'd0 || clr) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= '0;
            count_q   <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
            if (wd_d == WD_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_stall   = stall;
    assign o_pending = pending_q;
    assign o_count   = count_q;
    assign o_full    = (count_q == MAX_CNT);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios plus random traffic
// checked every cycle against a queue-based model of the pending set.
module tb_reg_scoreboard;

    localparam int MAX = 4;
    localparam int TO  = 8;
    localparam int CW  = $clog2(MAX + 1);

    localparam logic [6:0] R      = 7'b0110011;
    localparam logic [6:0] ST     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] PIM    = 7'b0001011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OPIMM  = 7'b0010011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = '0;
    logic [4:0]    rs1 = '0, rs2 = '0, rd = '0, wb_rd = '0;
    logic          valid = 1'b0, we = 1'b0, lng = 1'b0, wb_we = 1'b0;
    logic          stall, full, tmo;
    logic [31:0]   pend;
    logic [CW-1:0] cnt;

    int errors = 0;
    int checks = 0;

    int q[$];
    int wd_m = 0;
    bit to_m = 1'b0;

    reg_scoreboard #(
        .MAX_OUTSTANDING(MAX),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_opcode(opcode),
        .i_rs1(rs1),
        .i_rs2(rs2),
        .i_issue_valid(valid),
        .i_issue_reg_write(we),
        .i_issue_rd(rd),
        .i_issue_long(lng),
        .i_wb_reg_write(wb_we),
        .i_wb_rd(wb_rd),
        .o_stall(stall),
        .o_pending(pend),
        .o_count(cnt),
        .o_full(full),
        .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit inq(int r);
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit peff(int r);
        return r != 0 && inq(r) && !(wb_we && int'(wb_rd) == r);
    endfunction

    function automatic bit m_clr();
        return wb_we && wb_rd != 0 && inq(int'(wb_rd));
    endfunction

    function automatic bit m_stall();
        bit u1, u2, hz;
        if (rst) return 1'b0;
        u1 = !(opcode inside {JAL, LUI, AUIPC});
        u2 = opcode inside {R, ST, BR, PIM};
        hz = (u1 && peff(int'(rs1))) || (u2 && peff(int'(rs2)))
          || (we && peff(int'(rd)))
          || (lng && we && rd != 0 && q.size() == MAX && !m_clr());
        return valid && hz;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        foreach (q[i]) v[q[i]] = 1'b1;
        return v;
    endfunction

    task automatic m_reset();
        q.delete();
        wd_m = 0;
        to_m = 1'b0;
    endtask

    task automatic compare();
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("pending", pend, m_vec());
        chk("count", 32'(cnt), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == MAX));
        chk("timeout", 32'(tmo), 32'(to_m));
    endtask

    task automatic m_update();
        bit c, s, was_empty;
        if (rst) begin
            m_reset();
            return;
        end
        c = m_clr();
        s = valid && !m_stall() && lng && we && rd != 0;
        was_empty = (q.size() == 0);
        if (c) begin
            foreach (q[i]) if (q[i] == int'(wb_rd)) begin
                q.delete(i);
                break;
            end
        end
        if (s) q.push_back(int'(rd));
        if (was_empty || c) wd_m = 0;
        else if (wd_m < TO) wd_m++;
        if (wd_m == TO) to_m = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 0; we = 0; lng = 0; wb_we = 0;
        opcode = OPIMM; rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0;
    endtask

    task automatic dec(input logic [6:0] op, input int r1, input int r2,
                       input bit w, input int d, input bit l);
        valid = 1; opcode = op; rs1 = 5'(r1); rs2 = 5'(r2);
        we = w; rd = 5'(d); lng = l; wb_we = 0;
    endtask

    task automatic wb(input int r);
        wb_we = 1; wb_rd = 5'(r);
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        chk("rst_pending", pend, 32'h0);
        chk("rst_count", 32'(cnt), 32'h0);
        chk("rst_timeout", 32'(tmo), 32'h0);
        tick();
        rst = 0;
        m_reset();
        tick();

        // asynchronous reset with x5,x6 pending
        dec(LOAD, 0, 0, 1, 5, 1); tick();
        dec(LOAD, 0, 0, 1, 6, 1); tick();
        dec(R, 5, 0, 1, 10, 0); #1;
        chk("pre_rst_pending", pend, 32'h0000_0060);
        chk("pre_rst_stall", 32'(stall), 32'h1);
        #1 rst = 1; #1;
        chk("async_pending", pend, 32'h0);
        chk("async_count", 32'(cnt), 32'h0);
        chk("async_stall", 32'(stall), 32'h0);
        m_reset();
        tick();
        rst = 0; idle(); tick();

        // load-use
        dec(LOAD, 0, 0, 1, 5, 1); tick();
        dec(R, 5, 0, 1, 10, 0); #1;
        chk("lu_stall1", 32'(stall), 32'h1);
        tick();
        chk("lu_stall2", 32'(stall), 32'h1);
        tick();
        wb(5); #1;
        chk("lu_wb_stall", 32'(stall), 32'h0);
        tick();
        idle(); #1;
        chk("lu_pend5", 32'(pend[5]), 32'h0);
        tick();

        // operand masking
        dec(LOAD, 0, 0, 1, 7, 1); tick();
        dec(LUI, 7, 0, 1, 11, 0); #1;
        chk("lui_rs1", 32'(stall), 32'h0);
        tick();
        dec(OPIMM, 0, 7, 1, 12, 0); #1;
        chk("addi_rs2", 32'(stall), 32'h0);
        tick();
        dec(ST, 0, 7, 0, 0, 0); #1;
        chk("store_rs2", 32'(stall), 32'h1);
        tick();
        idle(); wb(7); tick();

        // WAW and x0
        dec(LOAD, 0, 0, 1, 9, 1); tick();
        dec(OPIMM, 0, 0, 1, 9, 0); #1;
        chk("waw", 32'(stall), 32'h1);
        tick();
        dec(LOAD, 0, 0, 1, 0, 1); #1;
        chk("x0_stall", 32'(stall), 32'h0);
        tick();
        idle(); #1;
        chk("x0_count", 32'(cnt), 32'h1);
        chk("x0_pend", pend, 32'h0000_0200);
        wb(9); tick();

        // full, then full with simultaneous clear
        for (int r = 1; r <= 4; r++) begin
            dec(LOAD, 0, 0, 1, r, 1); tick();
        end
        dec(LOAD, 0, 0, 1, 20, 1); #1;
        chk("full_flag", 32'(full), 32'h1);
        chk("full_stall", 32'(stall), 32'h1);
        tick();
        wb(3); #1;
        chk("full_clr_stall", 32'(stall), 32'h0);
        tick();
        idle(); #1;
        chk("full_clr_count", 32'(cnt), 32'h4);
        chk("full_clr_pend", pend, 32'h0010_0016);
        foreach (q[i]) ;
        wb(1); tick(); wb(2); tick(); wb(4); tick(); wb(20); tick();
        idle();

        // watchdog
        dec(LOAD, 0, 0, 1, 4, 1); tick();
        idle();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("wd_before", 32'(tmo), 32'h0);
        tick();
        chk("wd_fire", 32'(tmo), 32'h1);
        wb(4); tick();
        idle(); #1;
        chk("wd_sticky", 32'(tmo), 32'h1);
        chk("wd_pend", pend, 32'h0);
        rst = 1; #1;
        chk("wd_rst", 32'(tmo), 32'h0);
        m_reset();
        tick();
        rst = 0; tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] ops [9];
            ops = '{R, ST, BR, PIM, LUI, AUIPC, JAL, LOAD, OPIMM};
            opcode = ops[$urandom_range(0, 8)];
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            valid = ($urandom_range(0, 9) < 7);
            we = ($urandom_range(0, 9) < 8);
            lng = $urandom_range(0, 1);
            wb_we = ($urandom_range(0, 9) < 4);
            if (q.size() != 0 && $urandom_range(0, 9) < 7)
                wb_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wb_rd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                rst = 1; #1;
                chk("rnd_async_pend", pend, 32'h0);
                m_reset();
                tick();
                rst = 0;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side companion to the writeback forwarding logic. It tracks destination registers of in-flight multi-cycle operations (loads, PIM ops) from issue until writeback.
- Raises a decode-stage stall when an instruction reads a register, or would overwrite one, whose result is not yet available at writeback.
- Sits beside decode. Issue inputs come from decode; completion inputs come from the same writeback port that feeds operand forwarding.

Parameters:
- MAX_OUTSTANDING, 4, maximum simultaneously pending long-latency destinations (1..31).
- TIMEOUT_CYCLES, 1024, cycles without any completion while non-empty before o_timeout asserts (≥2).
- CNT_W, 11, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_opcode  in  7  opcode of instruction in decode.
- i_rs1  in  5  source register 1 of instruction in decode.
- i_rs2  in  5  source register 2 of instruction in decode.
- i_issue_valid  in  1  decode instruction is valid and attempting to issue.
- i_issue_reg_write  in  1  decode instruction writes rd.
- i_issue_rd  in  5  destination of decode instruction.
- i_issue_long  in  1  decode instruction is multi-cycle (load/PIM).
- i_wb_reg_write  in  1  writeback stage writes a register this cycle.
- i_wb_rd  in  5  writeback destination.
- o_stall  out  1  hold decode/fetch this cycle.
- o_pending  out  32  pending-register bit vector; bit 0 always 0.
- o_count  out  $clog2(MAX_OUTSTANDING+1)  number of pending registers.
- o_full  out  1  o_count == MAX_OUTSTANDING.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, i_rst=1): pending=0, count=0, watchdog=0, o_timeout=0. Consequently o_stall=0 and o_full=0.
- Operand usage matches forwarding:
  - rs1 is used unless opcode ∈ {JAL, LUI, AUIPC}.
  - rs2 is used only for opcode ∈ {R, STORE, BRANCH, PIM}.
  - x0 is never pending and never causes a stall.
- Effective pending for the hazard check: pend_eff = pending & ~(i_wb_reg_write ? onehot(i_wb_rd) : 0). A same-cycle writeback match is resolved by forwarding, not by stall.
- o_stall (combinational) = i_issue_valid & (RAW | WAW | FULL), where:
  - RAW = (rs1 used & pend_eff[rs1]) | (rs2 used & pend_eff[rs2]).
  - WAW = i_issue_reg_write & pend_eff[i_issue_rd].
  - FULL = i_issue_long & i_issue_reg_write & i_issue_rd≠0 & o_full & no clear this cycle.
- set = i_issue_valid & ~o_stall & i_issue_long & i_issue_reg_write & i_issue_rd≠0.
- clr = i_wb_reg_write & i_wb_rd≠0 & pending[i_wb_rd]. A writeback to a non-pending register is ignored for bookkeeping.
- Next state:
  - pending_next = (pending & ~clr_mask) | set_mask. Set is applied after clear, so a same-register clear+set leaves the bit at 1.
  - count: +1 on set only, −1 on clr only, unchanged on both or neither. Never exceeds MAX_OUTSTANDING and never underflows.
- Non-long instructions never set bits. Single-cycle results rely on forwarding.
- Watchdog:
  - Clears to 0 when pending==0 or clr.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - o_timeout sets when the counter reaches TIMEOUT_CYCLES. It stays set until i_rst.
  - It is debug-only and does not affect o_stall.
- Latency:
  - Stall is same-cycle combinational.
  - Issued bits are visible to the hazard check on the next cycle.
  - A clear is effective in the same cycle through pend_eff.

Test Plan:
- Reset mid-operation: with pending={x5,x6}, assert i_rst asynchronously. o_pending=0, o_count=0 and o_stall=0 without waiting for a clock edge.
- Load-use stall:
  - Issue long rd=x5, then decode ADD (opcode R) with rs1=x5 → o_stall=1 each cycle.
  - Writeback rd=x5 arrives → o_stall=0 in that same cycle; o_pending[5]=0 next cycle.
- Operand masking:
  - x7 pending; decode LUI with rs1 field=7 → o_stall=0.
  - Decode ADDI (I-type) with rs2 field=7 → o_stall=0.
  - Decode STORE with rs2=7 → o_stall=1.
- WAW and x0:
  - x9 pending; issue any reg-writing instruction with rd=x9 → o_stall=1.
  - Issue long with rd=x0 → no pending bit set; o_count unchanged.
- Full and simultaneous events:
  - MAX_OUTSTANDING=4 pending; long issue to rd=x20 → o_stall=1.
  - Same cycle as a writeback clearing x3 → o_stall=0; o_count stays 4; bit 3 cleared and bit 20 set.
- Watchdog (TIMEOUT_CYCLES=8):
  - x4 pending, no writeback for 8 cycles → o_timeout=1 and stays 1 after x4 writeback clears.
  - i_rst clears it.
